// File: rtl/image_resize_pkg.sv
// Shared defaults and state encoding for the image-resize line reader and
// its skid FIFO.
package image_resize_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 11;
  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_FRAC_WIDTH = 16;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } resize_rd_state_t;

endpackage

// File: rtl/image_resize_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read pipeline when the downstream stalls.
// Head entry is presented combinationally from storage registers.
module image_resize_skid_fifo
  import image_resize_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [1:0]       o_occupancy,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic w_push;
  logic w_pop;

  assign o_full      = (r_count == 2'd2);
  assign o_empty     = (r_count == 2'd0);
  assign o_occupancy = r_count;
  assign o_pop_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset because the head entry drives the output data
      // directly, which must read zero out of reset.
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/image_resize_line_reader.sv
// Horizontal nearest-neighbour resampler: walks a fixed-point source-column
// accumulator, reads the line RAM once per output pixel and streams the result.
module image_resize_line_reader
  import image_resize_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAC_WIDTH = DEFAULT_FRAC_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH:0]              src_width,
  input  logic [ADDR_WIDTH:0]              dst_width,
  input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_last,
  output logic                             busy,
  output logic                             done
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int STEP_W = ADDR_WIDTH + FRAC_WIDTH;
  localparam int ACC_W  = ADDR_WIDTH + FRAC_WIDTH + 2;
  localparam int POS_W  = ACC_W - FRAC_WIDTH;

  resize_rd_state_t        r_state;
  logic [CNT_W-1:0]        r_src_width;
  logic [CNT_W-1:0]        r_dst_width;
  logic [STEP_W-1:0]       r_step;
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_issued_cnt;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic                    r_in_flight;
  logic                    r_in_flight_last;
  logic                    r_busy;
  logic                    r_done;

  logic [ACC_W:0]          w_acc_sum;
  logic [ACC_W-1:0]        w_acc_next;
  logic [POS_W-1:0]        w_next_pos;
  logic [CNT_W-1:0]        w_src_max;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic [CNT_W-1:0]        w_issued_inc;
  logic                    w_last_issue;
  logic [1:0]              w_occupancy;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [DATA_WIDTH:0]     w_fifo_data;
  logic                    w_pop;
  logic [2:0]              w_credit_used;
  logic [2:0]              w_credit_avail;
  logic                    w_issue;

  // Accumulator saturates instead of wrapping so huge steps still clamp.
  assign w_acc_sum  = {1'b0, r_acc} + {3'b000, r_step};
  assign w_acc_next = w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
  assign w_next_pos = w_acc_next[ACC_W-1:FRAC_WIDTH];
  assign w_src_max  = r_src_width - CNT_W'(1);
  assign w_next_addr = (w_next_pos > {1'b0, w_src_max}) ? w_src_max[ADDR_WIDTH-1:0]
                                                        : w_next_pos[ADDR_WIDTH-1:0];

  assign w_issued_inc = r_issued_cnt + CNT_W'(1);
  assign w_last_issue = (w_issued_inc == r_dst_width);

  assign w_pop = m_valid && m_ready;

  // A read occupies one pipeline slot before it lands in the FIFO, so slots
  // plus entries (net of this cycle's pop) must stay below the FIFO depth.
  assign w_credit_used  = {1'b0, w_occupancy} + {2'b00, r_in_flight};
  assign w_credit_avail = 3'd2 + {2'b00, w_pop};
  assign w_issue        = (r_state == RUN) && (w_credit_used < w_credit_avail);

  image_resize_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_in_flight),
    .i_push_data ({r_in_flight_last, rd_data}),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_occupancy (w_occupancy),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_src_width      <= '0;
      r_dst_width      <= '0;
      r_step           <= '0;
      r_acc            <= '0;
      r_issued_cnt     <= '0;
      r_rd_addr        <= '0;
      r_in_flight      <= 1'b0;
      r_in_flight_last <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_done           <= 1'b0;
      r_in_flight      <= w_issue;
      r_in_flight_last <= w_issue && w_last_issue;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_src_width  <= src_width;
            r_dst_width  <= dst_width;
            r_step       <= step;
            r_acc        <= '0;
            r_issued_cnt <= '0;
            // Column 0 is always the first source pixel, whatever the width.
            r_rd_addr    <= '0;
            r_busy       <= 1'b1;
            r_state      <= (dst_width == '0) ? DRAIN : RUN;
          end
        end

        RUN: begin
          if (w_issue) begin
            r_acc        <= w_acc_next;
            r_issued_cnt <= w_issued_inc;
            if (w_last_issue) begin
              r_state <= DRAIN;
            end else begin
              r_rd_addr <= w_next_addr;
            end
          end
        end

        DRAIN: begin
          if ((r_dst_width == '0) || (w_pop && m_last)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr = r_rd_addr;
  assign m_valid = !w_fifo_empty;
  assign m_data  = w_fifo_data[DATA_WIDTH-1:0];
  assign m_last  = w_fifo_data[DATA_WIDTH];
  assign busy    = r_busy;
  assign done    = r_done;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_in_flight && w_fifo_full));

  a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule

// File: tb/tb_image_resize_line_reader.sv
// Scoreboard bench for image_resize_line_reader with a 1-cycle-latency line
// RAM model; expected beats are queued at start and popped on each handshake.
module tb_image_resize_line_reader;
  import image_resize_pkg::*;

  localparam int AW = 11;
  localparam int DW = 24;
  localparam int FW = 16;
  localparam longint ACC_MAX = (longint'(1) << (AW + FW + 2)) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW:0]       src_width;
  logic [AW:0]       dst_width;
  logic [AW+FW-1:0]  step;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0]   exp_q [$];
  logic [DW-1:0] ram [0:2047];

  image_resize_line_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FRAC_WIDTH(FW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_width (src_width),
    .dst_width (dst_width),
    .step      (step),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Line RAM: address sampled at the edge, data valid until the next edge.
  always @(posedge clk) rd_data <= ram[rd_addr];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [AW-1:0] model_addr(input int k, input int src, input int stp);
    longint acc;
    longint pos;
    acc = longint'(k) * longint'(stp);
    if (acc > ACC_MAX) acc = ACC_MAX;
    pos = acc >> FW;
    if (pos > longint'(src - 1)) pos = longint'(src - 1);
    return AW'(pos);
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1 && (cyc == 3 || (cyc >= 5 && cyc <= 9))) return 1'b0;
    return 1'b1;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the start edge.
  task automatic start_line(input int src, input int dst, input int stp);
    src_width = (AW+1)'(src);
    dst_width = (AW+1)'(dst);
    step      = (AW+FW)'(stp);
    start     = 1'b1;
    for (int k = 0; k < dst; k++) begin
      exp_q.push_back({(k == dst - 1), ram[model_addr(k, src, stp)]});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle 0 is the cycle right after the start edge; outputs sampled on negedge.
  task automatic run_stream(input int mode, input int pulse_cyc, output int beats,
                            output int first_cyc, output int last_cyc,
                            output int done_cyc, output int max_occ);
    int          cyc;
    bit          finished;
    bit          stalled;
    logic [DW:0] held;
    logic [DW:0] got;
    logic [DW:0] exp_beat;
    cyc = 0; finished = 0; stalled = 0; held = '0;
    beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; max_occ = 0;
    while (!finished && cyc < 300) begin
      m_ready = ready_for(mode, cyc);
      if (cyc == pulse_cyc) begin
        start = 1'b1; src_width = 12'd2; dst_width = 12'd2; step = 27'h10000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (int'(dut.u_fifo.o_occupancy) > max_occ) max_occ = int'(dut.u_fifo.o_occupancy);
      got = {m_last, m_data};
      if (m_valid && m_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got data=%h last=%b, expected no beat", m_data, m_last);
        end else begin
          exp_beat = exp_q.pop_front();
          if (got !== exp_beat) begin
            n_fail++;
            $display("FAIL beat%0d: got data=%h last=%b, expected data=%h last=%b",
                     beats, got[DW-1:0], got[DW], exp_beat[DW-1:0], exp_beat[DW]);
          end
        end
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        stalled  = 0;
      end else if (m_valid) begin
        if (!stalled) begin
          held    = got;
          stalled = 1;
        end else begin
          n_tests++;
          if (got !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got %h, expected held %h", got, held);
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        finished = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL stream_timeout: no done within %0d cycles", cyc);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_beats: %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    src_width = '0; dst_width = '0; step = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({rd_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h v=%b data=%h last=%b busy=%b done=%b, expected all 0",
               rd_addr, m_valid, m_data, m_last, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_downscale();
    int beats, first_cyc, last_cyc, done_cyc, max_occ;
    start_line(8, 4, 32'h20000);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ds_busy: got %b expected 1", busy); end
    run_stream(0, -1, beats, first_cyc, last_cyc, done_cyc, max_occ);
    n_tests++;
    if (beats != 4) begin n_fail++; $display("FAIL ds_beats: got %0d expected 4", beats); end
    n_tests++;
    if (first_cyc != 2) begin n_fail++; $display("FAIL ds_latency: got %0d expected 2", first_cyc); end
    n_tests++;
    if (last_cyc != 5) begin n_fail++; $display("FAIL ds_last_cyc: got %0d expected 5", last_cyc); end
    n_tests++;
    if (done_cyc != 6) begin n_fail++; $display("FAIL ds_done_cyc: got %0d expected 6", done_cyc); end
    n_tests++;
    if (rd_addr !== 11'd6) begin n_fail++; $display("FAIL ds_addr_hold: got %0d expected 6", rd_addr); end
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL ds_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_upscale();
    int beats, first_cyc, last_cyc, done_cyc, max_occ;
    start_line(4, 8, 32'h08000);
    run_stream(0, -1, beats, first_cyc, last_cyc, done_cyc, max_occ);
    n_tests++;
    if (beats != 8) begin n_fail++; $display("FAIL us_beats: got %0d expected 8", beats); end
    n_tests++;
    if (first_cyc != 2 || last_cyc != 9) begin
      n_fail++; $display("FAIL us_back_to_back: got first=%0d last=%0d expected 2 9", first_cyc, last_cyc);
    end
    n_tests++;
    if (done_cyc != 10) begin n_fail++; $display("FAIL us_done_cyc: got %0d expected 10", done_cyc); end
    n_tests++;
    if (rd_addr !== 11'd3) begin n_fail++; $display("FAIL us_addr_hold: got %0d expected 3", rd_addr); end
  endtask

  task automatic test_backpressure();
    int beats, first_cyc, last_cyc, done_cyc, max_occ;
    start_line(8, 4, 32'h20000);
    run_stream(1, -1, beats, first_cyc, last_cyc, done_cyc, max_occ);
    n_tests++;
    if (beats != 4) begin n_fail++; $display("FAIL bp_beats: got %0d expected 4", beats); end
    n_tests++;
    if (max_occ > 2) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected <= 2", max_occ); end
    n_tests++;
    if (last_cyc != 11 || done_cyc != 12) begin
      n_fail++; $display("FAIL bp_timing: got last=%0d done=%0d expected 11 12", last_cyc, done_cyc);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_clamp();
    int beats, first_cyc, last_cyc, done_cyc, max_occ;
    start_line(4, 3, 32'h20000);
    run_stream(0, -1, beats, first_cyc, last_cyc, done_cyc, max_occ);
    n_tests++;
    if (beats != 3) begin n_fail++; $display("FAIL clamp_beats: got %0d expected 3", beats); end
    n_tests++;
    if (rd_addr !== 11'd3) begin n_fail++; $display("FAIL clamp_addr: got %0d expected 3", rd_addr); end
  endtask

  task automatic test_degenerate();
    int beats, first_cyc, last_cyc, done_cyc, max_occ;
    start_line(8, 0, 32'h20000);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL dst0_busy: got %b expected 1", busy); end
    run_stream(0, -1, beats, first_cyc, last_cyc, done_cyc, max_occ);
    n_tests++;
    if (beats != 0 || done_cyc != 1) begin
      n_fail++; $display("FAIL dst0: got beats=%0d done_cyc=%0d expected 0 1", beats, done_cyc);
    end
    start_line(8, 4, 32'h20000);
    run_stream(0, 3, beats, first_cyc, last_cyc, done_cyc, max_occ);
    n_tests++;
    if (beats != 4 || done_cyc != 6) begin
      n_fail++; $display("FAIL busy_start: got beats=%0d done_cyc=%0d expected 4 6", beats, done_cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({m_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL busy_start_idle: got valid=%b busy=%b expected 0 0", m_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int beats, first_cyc, last_cyc, done_cyc, max_occ;
    m_ready = 1'b1;
    start_line(8, 4, 32'h20000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rd_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got addr=%h v=%b data=%h last=%b busy=%b done=%b, expected all 0",
               rd_addr, m_valid, m_data, m_last, busy, done);
    end
    n_tests++;
    if (dut.r_state !== IDLE) begin
      n_fail++; $display("FAIL midrst_state: got %0d expected IDLE", dut.r_state);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_line(8, 4, 32'h20000);
    run_stream(0, -1, beats, first_cyc, last_cyc, done_cyc, max_occ);
    n_tests++;
    if (beats != 4 || first_cyc != 2 || done_cyc != 6) begin
      n_fail++;
      $display("FAIL midrst_restart: got beats=%0d first=%0d done=%0d expected 4 2 6",
               beats, first_cyc, done_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 24'h100000 + 24'(i);
    test_reset();
    test_downscale();
    test_upscale();
    test_backpressure();
    test_clamp();
    test_degenerate();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
